// File: rtl/bf_pkg.sv
// Shared types and constants for the brute-force lane scheduler.
package bf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SELECT,
        ISSUE,
        WAIT,
        FOUND,
        EXHAUSTED
    } bf_state_t;

    localparam logic [7:0] ASCII_A    = 8'h61;
    localparam int         ARM_CYCLES = 2;
    localparam int         CHAR_BITS  = 8;

    // A zero length still searches single characters; lengths past the generator limit are clipped.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_chars);
        logic [3:0] res;
        res = len;
        if (len == 4'd0) begin
            res = 4'd1;
        end else if (int'(len) > max_chars) begin
            res = 4'(max_chars);
        end
        return res;
    endfunction

endpackage

// File: rtl/bf_rr_arbiter.sv
// Masked round-robin arbiter: grants the first requesting lane at or after ptr, wrapping to lane 0.
// Latency: combinational. Backpressure: none; grant is only meaningful when none_valid is low.
module bf_rr_arbiter #(
    parameter int NUM_LANES = 4
) (
    input  logic [NUM_LANES-1:0] request,
    input  logic [2:0]           ptr,
    output logic [NUM_LANES-1:0] grant,
    output logic [2:0]           grant_idx,
    output logic                 none_valid
);

    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        none_valid = 1'b1;
        for (int j = 0; j < NUM_LANES; j++) begin
            if (none_valid && request[j] && (3'(j) >= ptr)) begin
                grant[j]   = 1'b1;
                grant_idx  = 3'(j);
                none_valid = 1'b0;
            end
        end
        // Second pass covers the wrap from the top lane back to lane 0.
        for (int j = 0; j < NUM_LANES; j++) begin
            if (none_valid && request[j] && (3'(j) < ptr)) begin
                grant[j]   = 1'b1;
                grant_idx  = 3'(j);
                none_valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bf_lane_scheduler.sv
// Round-robin scheduler feeding one shared password checker from NUM_LANES candidate generators.
// Latency: start -> first chk_valid 4 cycles later; backpressure: candidate held in ISSUE until chk_ready, one outstanding.
module bf_lane_scheduler
    import bf_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int MAX_CHARS = 8,
    parameter int PW_W      = 128,
    parameter int CNT_W     = 40
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [3:0]                max_len,
    output logic                      lane_enable,
    output logic [8*NUM_LANES-1:0]    lane_start_pos,
    output logic [2:0]                lane_increment,
    output logic [NUM_LANES-1:0]      lane_ready,
    input  logic [PW_W*NUM_LANES-1:0] lane_password,
    input  logic [8*NUM_LANES-1:0]    lane_num_chars,
    output logic                      chk_valid,
    input  logic                      chk_ready,
    output logic [PW_W-1:0]           chk_password,
    input  logic                      res_valid,
    input  logic                      res_match,
    output logic                      busy,
    output logic                      found,
    output logic                      exhausted,
    output logic [PW_W-1:0]           found_password,
    output logic [2:0]                found_lane,
    output logic [CNT_W-1:0]          attempts
);

    bf_state_t            state;
    bf_state_t            state_nxt;
    logic [1:0]           arm_cnt;
    logic [NUM_LANES-1:0] lane_done;
    logic [NUM_LANES-1:0] cur_grant;
    logic [NUM_LANES-1:0] grant;
    logic [2:0]           rr_ptr;
    logic [2:0]           cur_lane;
    logic [2:0]           grant_idx;
    logic                 none_valid;
    logic [3:0]           max_len_q;
    logic [7:0]           limit_bits;
    logic [7:0]           cand_len;
    logic [PW_W-1:0]      cand_pw;
    logic                 too_long;
    logic                 idle_like;
    logic                 start_go;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_start_pos
        assign lane_start_pos[8*i +: 8] = ASCII_A + 8'(i);
    end

    assign lane_increment = 3'(NUM_LANES);

    bf_rr_arbiter #(
        .NUM_LANES (NUM_LANES)
    ) u_arb (
        .request    (~lane_done),
        .ptr        (rr_ptr),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .none_valid (none_valid)
    );

    always_comb begin
        cand_len = '0;
        cand_pw  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (grant[i]) begin
                cand_len = lane_num_chars[8*i +: 8];
                cand_pw  = lane_password[PW_W*i +: PW_W];
            end
        end
    end

    assign limit_bits = 8'(max_len_q) * 8'(CHAR_BITS);
    assign too_long   = cand_len > limit_bits;

    assign idle_like   = (state == IDLE) || (state == FOUND) || (state == EXHAUSTED);
    assign busy        = !idle_like;
    assign lane_enable = busy;
    assign chk_valid   = (state == ISSUE);
    assign start_go    = (state_nxt == ARM) && (state != ARM);
    // An abort in the handshake cycle cancels the advance, so the lane keeps its candidate.
    assign lane_ready  = (state == ISSUE && chk_ready && !abort) ? cur_grant : '0;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FOUND, EXHAUSTED: if (start) state_nxt = ARM;
            ARM:    if (arm_cnt == 2'(ARM_CYCLES - 1)) state_nxt = SELECT;
            SELECT: begin
                if (none_valid) begin
                    state_nxt = EXHAUSTED;
                end else if (!too_long) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE:  if (chk_ready) state_nxt = WAIT;
            WAIT:   if (res_valid) state_nxt = res_match ? FOUND : SELECT;
            default: state_nxt = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            arm_cnt        <= '0;
            lane_done      <= '0;
            cur_grant      <= '0;
            cur_lane       <= '0;
            rr_ptr         <= '0;
            max_len_q      <= '0;
            chk_password   <= '0;
            found          <= 1'b0;
            exhausted      <= 1'b0;
            found_password <= '0;
            found_lane     <= '0;
            attempts       <= '0;
        end else begin
            arm_cnt <= (state == ARM) ? arm_cnt + 2'd1 : 2'd0;
            if (start_go) begin
                found     <= 1'b0;
                exhausted <= 1'b0;
                attempts  <= '0;
                lane_done <= '0;
                rr_ptr    <= '0;
                max_len_q <= clamp_len(max_len, MAX_CHARS);
            end
            if (!abort) begin
                case (state)
                    SELECT: begin
                        if (none_valid) begin
                            exhausted <= 1'b1;
                        end else if (too_long) begin
                            lane_done <= lane_done | grant;
                        end else begin
                            chk_password <= cand_pw;
                            cur_grant    <= grant;
                            cur_lane     <= grant_idx;
                            rr_ptr       <= (grant_idx == 3'(NUM_LANES - 1)) ? 3'd0 : grant_idx + 3'd1;
                        end
                    end
                    ISSUE: begin
                        if (chk_ready && attempts != {CNT_W{1'b1}}) begin
                            attempts <= attempts + 1'b1;
                        end
                    end
                    WAIT: begin
                        if (res_valid && res_match) begin
                            found          <= 1'b1;
                            found_password <= chk_password;
                            found_lane     <= cur_lane;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
